// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: word size, bubble instruction, fetch FSM encodings.
package pipeline_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] DEFAULT_NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_RUN  = 2'd1,
    FS_HALT = 2'd2
  } fetch_state_e;

  typedef enum logic [2:0] {
    ACT_NONE    = 3'd0,
    ACT_FLUSH   = 3'd1,
    ACT_HALT    = 3'd2,
    ACT_STALL   = 3'd3,
    ACT_FAULT   = 3'd4,
    ACT_ADVANCE = 3'd5
  } fetch_act_e;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// Generic stage register: pc/inst/valid with hold and bubble controls (bubble wins over hold).
module if_id_reg
  import pipeline_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_INST = DEFAULT_NOP_INST
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            hold_i,
  input  logic            bubble_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] inst_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] inst_o,
  output logic            valid_o
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] inst_q;
  logic            valid_q;

  // Stage contents: reset/bubble load a NOP, hold keeps, otherwise capture.
  always_ff @(posedge clk) begin
    if (rst || bubble_i) begin
      pc_q    <= 32'h0000_0000;
      inst_q  <= NOP_INST;
      valid_q <= 1'b0;
    end else if (hold_i) begin
      pc_q    <= pc_q;
      inst_q  <= inst_q;
      valid_q <= valid_q;
    end else begin
      pc_q    <= pc_i;
      inst_q  <= inst_i;
      valid_q <= 1'b1;
    end
  end

  assign pc_o    = pc_q;
  assign inst_o  = inst_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC, fetch FSM, capture counter and out-of-range fault; feeds the IF/ID register.
module fetch_stage
  import pipeline_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned     MEM_WORDS = 1001,
  parameter logic [XLEN-1:0] NOP_INST  = DEFAULT_NOP_INST
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            halt_i,
  output logic            inst_ce_o,
  output logic [XLEN-1:0] inst_addr_o,
  input  logic [XLEN-1:0] inst_i,
  output logic [XLEN-1:0] if_id_pc_o,
  output logic [XLEN-1:0] if_id_inst_o,
  output logic            if_id_valid_o,
  output logic [XLEN-1:0] fetch_cnt_o,
  output logic            fault_o
);

  localparam logic [XLEN-1:0] MEM_WORDS_W = 32'(MEM_WORDS);

  fetch_state_e    state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] cnt_q;
  logic            fault_q;
  fetch_act_e      act_d;
  logic            hold_d;
  logic            bubble_d;

  // Resolve this edge's action with priority flush > halt > stall > fault > advance.
  always_comb begin
    act_d = ACT_NONE;
    if (state_q == FS_RUN) begin
      if (flush_i) begin
        act_d = ACT_FLUSH;
      end else if (halt_i) begin
        act_d = ACT_HALT;
      end else if (stall_i) begin
        act_d = ACT_STALL;
      end else if ({2'b00, pc_q[XLEN-1:2]} >= MEM_WORDS_W) begin
        act_d = ACT_FAULT;
      end else begin
        act_d = ACT_ADVANCE;
      end
    end else begin
      act_d = ACT_NONE;
    end
    hold_d   = (act_d == ACT_STALL);
    bubble_d = (act_d != ACT_STALL) && (act_d != ACT_ADVANCE);
  end

  // Fetch FSM together with PC, capture counter and sticky fault.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FS_IDLE;
      pc_q    <= word_align(RESET_PC);
      cnt_q   <= 32'h0000_0000;
      fault_q <= 1'b0;
    end else begin
      case (state_q)
        FS_IDLE: state_q <= FS_RUN;
        FS_RUN: begin
          case (act_d)
            ACT_FLUSH: pc_q <= word_align(redirect_pc_i);
            ACT_HALT:  state_q <= FS_HALT;
            ACT_FAULT: begin
              fault_q <= 1'b1;
              state_q <= FS_HALT;
            end
            ACT_ADVANCE: begin
              pc_q  <= pc_q + 32'd4;
              cnt_q <= (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;
            end
            default: pc_q <= pc_q;
          endcase
        end
        FS_HALT: state_q <= FS_HALT;
        default: state_q <= FS_IDLE;
      endcase
    end
  end

  if_id_reg #(.NOP_INST(NOP_INST)) u_if_id (
    .clk      (clk),
    .rst      (rst),
    .hold_i   (hold_d),
    .bubble_i (bubble_d),
    .pc_i     (pc_q),
    .inst_i   (inst_i),
    .pc_o     (if_id_pc_o),
    .inst_o   (if_id_inst_o),
    .valid_o  (if_id_valid_o)
  );

  assign inst_ce_o   = (state_q == FS_RUN);
  assign inst_addr_o = pc_q;
  assign fetch_cnt_o = cnt_q;
  assign fault_o     = fault_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios with literal expectations, then randomized
// traffic compared every cycle against a behavioural model of the fetch rules.
module tb_fetch_stage;

  localparam int          MEM_WORDS = 1001;
  localparam logic [31:0] NOP       = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, stall, flush, halt;
  logic [31:0] redirect;
  logic        ce;
  logic [31:0] addr, inst, if_pc, if_inst, cnt;
  logic        if_valid, fault;

  logic [31:0] mem [MEM_WORDS];

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'h0000_0000), .MEM_WORDS(MEM_WORDS), .NOP_INST(NOP)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall_i       (stall),
    .flush_i       (flush),
    .redirect_pc_i (redirect),
    .halt_i        (halt),
    .inst_ce_o     (ce),
    .inst_addr_o   (addr),
    .inst_i        (inst),
    .if_id_pc_o    (if_pc),
    .if_id_inst_o  (if_inst),
    .if_id_valid_o (if_valid),
    .fetch_cnt_o   (cnt),
    .fault_o       (fault)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    int idx;
    idx = int'(a >> 2);
    if (a < 32'(4 * MEM_WORDS)) return mem[idx];
    else return 32'h0000_0000;
  endfunction

  // Combinational instruction memory seen by the DUT.
  always_comb begin
    inst = 32'h0000_0000;
    if (ce) inst = mem_word(addr);
  end

  // Behavioural model: mode 0 = first cycle out of reset, 1 = fetching, 2 = stopped.
  int          m_mode;
  logic [31:0] m_pc, m_ifpc, m_ifinst, m_cnt;
  logic        m_ifv, m_fault;

  task automatic m_bubble();
    m_ifpc = 32'h0; m_ifinst = NOP; m_ifv = 1'b0;
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_mode = 0; m_pc = 32'h0; m_cnt = 32'h0; m_fault = 1'b0;
      m_bubble();
    end else if (m_mode == 0) begin
      m_mode = 1;
      m_bubble();
    end else if (m_mode == 2) begin
      m_bubble();
    end else if (flush) begin
      m_pc = {redirect[31:2], 2'b00};
      m_bubble();
    end else if (halt) begin
      m_mode = 2;
      m_bubble();
    end else if (stall) begin
      m_mode = 1;
    end else if (m_pc / 4 >= MEM_WORDS) begin
      m_fault = 1'b1; m_mode = 2;
      m_bubble();
    end else begin
      m_ifpc = m_pc; m_ifinst = mem_word(m_pc); m_ifv = 1'b1;
      m_pc = m_pc + 32'd4;
      if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_ce", 32'(ce), 32'(m_mode == 1));
      chk("m_addr", addr, m_pc);
      chk("m_valid", 32'(if_valid), 32'(m_ifv));
      chk("m_inst", if_inst, m_ifinst);
      if (m_ifv) chk("m_ifpc", if_pc, m_ifpc);
      chk("m_cnt", cnt, m_cnt);
      chk("m_fault", 32'(fault), 32'(m_fault));
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    for (int k = 0; k < MEM_WORDS; k++) mem[k] = 32'(k + 1) * 32'h11;
    rst = 1'b1; stall = 1'b0; flush = 1'b0; halt = 1'b0; redirect = 32'h0;
    @(posedge clk);
    cmp_en = 1'b1;
    @(negedge clk);
    tick();
    chk("rst_ce", 32'(ce), 32'h0);
    chk("rst_valid", 32'(if_valid), 32'h0);
    chk("rst_inst", if_inst, 32'h0000_0013);
    chk("rst_ifpc", if_pc, 32'h0);
    chk("rst_addr", addr, 32'h0);
    chk("rst_cnt", cnt, 32'h0);
    rst = 1'b0;
    chk("idle_ce", 32'(ce), 32'h0);
    tick();
    chk("run_ce", 32'(ce), 32'h1);
    chk("run_valid", 32'(if_valid), 32'h0);
    tick();
    chk("first_ifpc", if_pc, 32'h0);
    chk("first_inst", if_inst, 32'h11);
    chk("first_valid", 32'(if_valid), 32'h1);
    tick();
    chk("pc8", addr, 32'h8);
    stall = 1'b1;
    repeat (3) begin
      tick();
      chk("stall_addr", addr, 32'h8);
      chk("stall_ifpc", if_pc, 32'h4);
      chk("stall_inst", if_inst, 32'h22);
      chk("stall_cnt", cnt, 32'd2);
    end
    stall = 1'b0;
    tick();
    chk("resume_addr", addr, 32'hC);
    chk("resume_ifpc", if_pc, 32'h8);
    repeat (2) tick();
    chk("cnt5", cnt, 32'd5);
    chk("inst55", if_inst, 32'h55);
    flush = 1'b1; stall = 1'b1; redirect = 32'h23;
    tick();
    chk("flush_addr", addr, 32'h20);
    chk("flush_valid", 32'(if_valid), 32'h0);
    chk("flush_inst", if_inst, 32'h13);
    chk("flush_cnt", cnt, 32'd5);
    flush = 1'b0; stall = 1'b0;
    tick();
    chk("redir_ifpc", if_pc, 32'h20);
    chk("redir_inst", if_inst, 32'h99);
    chk("redir_valid", 32'(if_valid), 32'h1);
    flush = 1'b1; redirect = 32'h10;
    tick();
    flush = 1'b0; halt = 1'b1;
    tick();
    halt = 1'b0;
    repeat (10) begin
      flush = 1'($urandom); stall = 1'($urandom); redirect = $urandom;
      tick();
      chk("halt_ce", 32'(ce), 32'h0);
      chk("halt_addr", addr, 32'h10);
      chk("halt_valid", 32'(if_valid), 32'h0);
    end
    flush = 1'b0; stall = 1'b0;
    rst = 1'b1;
    tick();
    chk("halt_rst_addr", addr, 32'h0);
    rst = 1'b0;
    repeat (2) tick();
    flush = 1'b1; redirect = 32'h0000_0FA0;
    tick();
    flush = 1'b0;
    chk("last_addr", addr, 32'hFA0);
    tick();
    chk("last_ifpc", if_pc, 32'hFA0);
    chk("last_inst", if_inst, 32'h0000_4279);
    chk("last_fault", 32'(fault), 32'h0);
    tick();
    chk("fault_set", 32'(fault), 32'h1);
    chk("fault_valid", 32'(if_valid), 32'h0);
    chk("fault_ce", 32'(ce), 32'h0);
    repeat (3) tick();
    chk("fault_sticky", 32'(fault), 32'h1);
    chk("fault_cnt", cnt, 32'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (4) tick();
    rst = 1'b1; flush = 1'b1; redirect = 32'h100;
    tick();
    chk("rstflush_addr", addr, 32'h0);
    chk("rstflush_valid", 32'(if_valid), 32'h0);
    chk("rstflush_cnt", cnt, 32'h0);
    chk("rstflush_ce", 32'(ce), 32'h0);
    rst = 1'b0; flush = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      rst   = (m_mode == 2) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 299) == 0);
      stall = ($urandom_range(0, 99) < 25);
      flush = ($urandom_range(0, 99) < 10);
      halt  = ($urandom_range(0, 99) < 2);
      case ($urandom_range(0, 3))
        0:       redirect = 32'($urandom_range(0, 64));
        1:       redirect = 32'($urandom_range(32'hF80, 32'hFC0));
        2:       redirect = $urandom;
        default: redirect = 32'($urandom_range(0, 32'hFA4));
      endcase
      tick();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
